pipelined_cla_adder: RTL and testbench

//  N-bit add/subtract unit built from CLA segments and split into STAGES

---
 rtl/pipelined_cla_adder_if.sv | 30 +++
 rtl/pipelined_cla_adder.sv | 139 +++++++++++++
 tb/tb_pipelined_cla_adder.sv | 295 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pipelined_cla_adder_if.sv
// Operand/result handshake bundle for pipelined_cla_adder (macro CLA_SAT_EN is consumed by the adder, not here).
// Latency: none, wires only.
// Backpressure: in_ready/out_ready carry the stall information in each direction.
interface pipelined_cla_adder_if #(
    parameter int N = 16
);
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         sub;
    logic         cin;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] result;
    logic         cout;
    logic         ovf;

    // producer of operands / consumer of results
    modport master (
        output in_valid, a, b, sub, cin, out_ready,
        input  in_ready, out_valid, result, cout, ovf
    );

    // the adder itself
    modport slave (
        input  in_valid, a, b, sub, cin, out_ready,
        output in_ready, out_valid, result, cout, ovf
    );
endinterface

// File: rtl/pipelined_cla_adder.sv
// Pipelined N-bit add/subtract from STAGES CLA segments; define CLA_SAT_EN to saturate the result on signed overflow.
// Latency: STAGES cycles from input transfer to out_valid, one operation per cycle.
// Backpressure: out_ready low freezes the last stage; stalls propagate combinationally to in_ready (no skid buffer).
module pipelined_cla_adder #(
    parameter int N      = 16,
    parameter int STAGES = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    pipelined_cla_adder_if.slave bus
);
    localparam int W = N / STAGES;

    if (N % STAGES != 0) begin : g_bad_cfg
        $error("pipelined_cla_adder: N (%0d) must be a multiple of STAGES (%0d)", N, STAGES);
    end

    // Stage k register: operands travel forward whole, sum bits [0 +: (k+1)*W] are final.
    logic [STAGES-1:0] v_q;
    logic [N-1:0]      a_q [STAGES];
    logic [N-1:0]      b_q [STAGES];   // already inverted in subtract mode
    logic [N-1:0]      s_q [STAGES];
    logic [STAGES-1:0] c_q;            // carry out of the segment this stage resolved
    logic              ovf_q;

    // What each stage sees at its input, and what it would load.
    logic [STAGES-1:0] v_src;
    logic [N-1:0]      a_src [STAGES];
    logic [N-1:0]      b_src [STAGES];
    logic [N-1:0]      s_src [STAGES];
    logic [N-1:0]      s_nxt [STAGES];
    logic [STAGES-1:0] c_src;
    logic [STAGES-1:0] c_nxt;
    logic              ovf_nxt;
    logic              carry;
    logic              c_msb;
    logic              g;
    logic              p;

    logic [STAGES-1:0] adv;   // stage k's content may move on this edge
    logic [STAGES-1:0] ld;    // stage k captures its input on this edge

    // Stall chain: a stage can move if the next one is empty or moving itself.
    always_comb begin
        adv = '0;
        adv[STAGES-1] = !v_q[STAGES-1] || bus.out_ready;
        for (int k = STAGES - 2; k >= 0; k--) begin
            adv[k] = !v_q[k+1] || adv[k+1];
        end
        ld = ~v_q | adv;
    end

    // Segment k resolves bits [k*W +: W] using the carry left by segment k-1.
    always_comb begin
        v_src    = '0;
        c_src    = '0;
        c_nxt    = '0;
        a_src    = '{default: '0};
        b_src    = '{default: '0};
        s_src    = '{default: '0};
        s_nxt    = '{default: '0};
        carry    = 1'b0;
        c_msb    = 1'b0;
        g        = 1'b0;
        p        = 1'b0;
        ovf_nxt  = 1'b0;

        v_src[0] = bus.in_valid;
        a_src[0] = bus.a;
        b_src[0] = bus.sub ? ~bus.b : bus.b;
        c_src[0] = bus.sub ? 1'b1 : bus.cin;
        for (int k = 1; k < STAGES; k++) begin
            v_src[k] = v_q[k-1];
            a_src[k] = a_q[k-1];
            b_src[k] = b_q[k-1];
            s_src[k] = s_q[k-1];
            c_src[k] = c_q[k-1];
        end

        for (int k = 0; k < STAGES; k++) begin
            carry    = c_src[k];
            s_nxt[k] = s_src[k];
            for (int i = 0; i < W; i++) begin
                g                    = a_src[k][k*W+i] & b_src[k][k*W+i];
                p                    = a_src[k][k*W+i] ^ b_src[k][k*W+i];
                s_nxt[k][k*W+i]      = p ^ carry;
                c_msb                = carry;
                carry                = g | (p & carry);
            end
            c_nxt[k] = carry;
        end

        // The last iteration above was the top segment, so c_msb/carry are the
        // carries into and out of bit N-1.
        ovf_nxt = c_msb ^ carry;
`ifdef CLA_SAT_EN
        // On overflow the wrapped MSB is the opposite of the true sign.
        if (ovf_nxt) begin
            s_nxt[STAGES-1] = s_nxt[STAGES-1][N-1] ? {1'b0, {(N-1){1'b1}}}
                                                   : {1'b1, {(N-1){1'b0}}};
        end
`endif
    end

    // Stage registers: capture when allowed, payload only when a valid op arrives.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_q   <= '0;
            c_q   <= '0;
            ovf_q <= 1'b0;
            for (int k = 0; k < STAGES; k++) begin
                a_q[k] <= '0;
                b_q[k] <= '0;
                s_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                if (ld[k]) begin
                    v_q[k] <= v_src[k];
                    if (v_src[k]) begin
                        a_q[k] <= a_src[k];
                        b_q[k] <= b_src[k];
                        s_q[k] <= s_nxt[k];
                        c_q[k] <= c_nxt[k];
                    end
                end
            end
            if (ld[STAGES-1] && v_src[STAGES-1]) begin
                ovf_q <= ovf_nxt;
            end
        end
    end

    assign bus.in_ready  = ld[0];
    assign bus.out_valid = v_q[STAGES-1];
    assign bus.result    = s_q[STAGES-1];
    assign bus.cout      = c_q[STAGES-1];
    assign bus.ovf       = ovf_q;
endmodule

// File: tb/tb_pipelined_cla_adder.sv
// Bench for pipelined_cla_adder: directed vectors and corner sequences on STAGES=4, random traffic on STAGES 1/2/4/16.
// Latency: checks exactly STAGES cycles per isolated operation.
// Backpressure: random in_valid/out_ready, capacity fill and output hold under stall.
module tb_pipelined_cla_adder;
    localparam int N     = 16;
    localparam int STG   = 4;
    localparam int N_RND = 1000;
`ifdef CLA_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_tests  = 0;
    int   n_fail   = 0;
    bit   rnd_go   = 1'b0;
    int   rnd_done = 0;

    always #5 clk = ~clk;

    typedef struct packed {
        logic         cout;
        logic         ovf;
        logic [N-1:0] res;
    } res_t;

    typedef struct {
        logic [N-1:0] a;
        logic [N-1:0] b;
        logic         sub;
        logic         cin;
        logic [N-1:0] res;
        logic         cout;
        logic         ovf;
    } vec_t;

    // Reference: true signed/unsigned arithmetic on plain integers.
    function automatic res_t model(input logic [N-1:0] a, input logic [N-1:0] b,
                                   input logic sub, input logic cin);
        int   sa, sb, ua, ub, t;
        res_t r;
        sa = int'($signed(a));
        sb = int'($signed(b));
        ua = int'(a);
        ub = int'(b);
        if (sub) begin
            t      = sa - sb;
            r.cout = (ua >= ub);
        end else begin
            t      = sa + sb + int'(cin);
            r.cout = (ua + ub + int'(cin)) > 65535;
        end
        r.ovf = (t > 32767) || (t < -32768);
        r.res = t[N-1:0];
        if (SAT && t > 32767)  r.res = 16'h7FFF;
        if (SAT && t < -32768) r.res = 16'h8000;
        return r;
    endfunction

    function automatic logic [N-1:0] pick();
        case ($urandom_range(0, 7))
            0:       return 16'h7FFF;
            1:       return 16'h8000;
            2:       return 16'hFFFF;
            3:       return 16'h0000;
            default: return 16'($urandom);
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    pipelined_cla_adder_if #(.N(N)) ifc();
    pipelined_cla_adder #(.N(N), .STAGES(STG)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifc)
    );

    // Random traffic against the model, one DUT per depth.
    for (genvar gi = 0; gi < 4; gi++) begin : g_rnd
        localparam int S = (gi == 0) ? 1 : (gi == 1) ? 2 : (gi == 2) ? 4 : 16;
        pipelined_cla_adder_if #(.N(N)) rif();
        pipelined_cla_adder #(.N(N), .STAGES(S)) u_rnd (
            .clk   (clk),
            .rst_n (rst_n),
            .bus   (rif)
        );
        res_t exp_q[$];
        res_t e;
        int   sent;
        int   recv;
        int   cyc;
        bit   acc;

        initial begin
            rif.in_valid  = 1'b0;
            rif.a         = '0;
            rif.b         = '0;
            rif.sub       = 1'b0;
            rif.cin       = 1'b0;
            rif.out_ready = 1'b0;
            sent = 0;
            recv = 0;
            cyc  = 0;
            acc  = 1'b0;
            wait (rnd_go);
            while (recv < N_RND && cyc < 20000) begin
                tick();
                cyc++;
                if (!rif.in_valid || acc) begin
                    if (sent < N_RND && $urandom_range(0, 1) == 1) begin
                        rif.a        = pick();
                        rif.b        = pick();
                        rif.sub      = 1'($urandom_range(0, 1));
                        rif.cin      = 1'($urandom_range(0, 1));
                        rif.in_valid = 1'b1;
                    end else begin
                        rif.in_valid = 1'b0;
                    end
                end
                rif.out_ready = 1'($urandom_range(0, 1));
                @(negedge clk);
                acc = rif.in_valid && rif.in_ready;
                if (acc) begin
                    exp_q.push_back(model(rif.a, rif.b, rif.sub, rif.cin));
                    sent++;
                end
                if (rif.out_valid && rif.out_ready) begin
                    if (exp_q.size() == 0) begin
                        check($sformatf("S%0d_unexpected_out", S), 32'(exp_q.size()), 32'd1);
                    end else begin
                        e = exp_q.pop_front();
                        check($sformatf("S%0d_op%0d", S, recv),
                              32'({rif.cout, rif.ovf, rif.result}), 32'(e));
                    end
                    recv++;
                end
            end
            rif.in_valid  = 1'b0;
            rif.out_ready = 1'b1;
            check($sformatf("S%0d_recv_count", S), 32'(recv), 32'(N_RND));
            check($sformatf("S%0d_left_in_model", S), 32'(exp_q.size()), 32'd0);
            tick();
            @(negedge clk);
            check($sformatf("S%0d_idle_after", S), 32'(rif.out_valid), 32'd0);
            rnd_done++;
        end
    end

    vec_t          vecs[10];
    int            lat;
    int            acc_n;
    bit            ir;
    logic [N-1:0]  got[$];

    initial begin
        vecs[0] = '{16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100,               1'b0, 1'b0};
        vecs[1] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, SAT ? 16'h7FFF : 16'h8000, 1'b0, 1'b1};
        vecs[2] = '{16'h0005, 16'h0007, 1'b1, 1'b0, 16'hFFFE,               1'b0, 1'b0};
        vecs[3] = '{16'hFFFF, 16'hFFFF, 1'b0, 1'b1, 16'hFFFF,               1'b1, 1'b0};
        vecs[4] = '{16'h8000, 16'h0001, 1'b1, 1'b0, SAT ? 16'h8000 : 16'h7FFF, 1'b1, 1'b1};
        vecs[5] = '{16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0000,               1'b1, 1'b0};
        vecs[6] = '{16'h8000, 16'h8000, 1'b0, 1'b0, SAT ? 16'h8000 : 16'h0000, 1'b1, 1'b1};
        vecs[7] = '{16'h1234, 16'h4321, 1'b0, 1'b1, 16'h5556,               1'b0, 1'b0};
        vecs[8] = '{16'h0010, 16'h0001, 1'b1, 1'b1, 16'h000F,               1'b1, 1'b0};
        vecs[9] = '{16'h7FFF, 16'hFFFF, 1'b1, 1'b0, SAT ? 16'h7FFF : 16'h8000, 1'b0, 1'b1};

        ifc.in_valid  = 1'b0;
        ifc.a         = '0;
        ifc.b         = '0;
        ifc.sub       = 1'b0;
        ifc.cin       = 1'b0;
        ifc.out_ready = 1'b1;

        // Reset state
        #12;
        check("rst_in_ready",  32'(ifc.in_ready),  32'd1);
        check("rst_out_valid", 32'(ifc.out_valid), 32'd0);
        check("rst_result",    32'(ifc.result),    32'd0);
        check("rst_cout",      32'(ifc.cout),      32'd0);
        check("rst_ovf",       32'(ifc.ovf),       32'd0);
        tick();
        rst_n = 1'b1;
        tick();

        // Isolated operations: latency and value
        for (int i = 0; i < 10; i++) begin
            ifc.a        = vecs[i].a;
            ifc.b        = vecs[i].b;
            ifc.sub      = vecs[i].sub;
            ifc.cin      = vecs[i].cin;
            ifc.in_valid = 1'b1;
            tick();
            ifc.in_valid = 1'b0;
            lat = 1;
            while (!ifc.out_valid && lat < 20) begin
                tick();
                lat++;
            end
            check($sformatf("vec%0d_latency", i), 32'(lat),         32'(STG));
            check($sformatf("vec%0d_result", i),  32'(ifc.result), 32'(vecs[i].res));
            check($sformatf("vec%0d_cout", i),    32'(ifc.cout),   32'(vecs[i].cout));
            check($sformatf("vec%0d_ovf", i),     32'(ifc.ovf),    32'(vecs[i].ovf));
            tick();
        end

        // Capacity under a stalled output, hold, then simultaneous in/out at full occupancy
        ifc.out_ready = 1'b0;
        ifc.b   = '0;
        ifc.sub = 1'b0;
        ifc.cin = 1'b0;
        acc_n   = 0;
        for (int c = 0; c < 10; c++) begin
            ifc.a        = 16'(acc_n + 1);
            ifc.in_valid = 1'b1;
            ir = ifc.in_ready;
            tick();
            if (ir) acc_n++;
        end
        check("cap_accepted",  32'(acc_n),        32'(STG));
        check("cap_in_ready",  32'(ifc.in_ready), 32'd0);
        check("hold_result_0", 32'(ifc.result),   32'h1);
        tick();
        tick();
        check("hold_result_1", 32'(ifc.result),    32'h1);
        check("hold_valid",    32'(ifc.out_valid), 32'd1);
        ifc.out_ready = 1'b1;
        #1;
        check("full_simul_in_ready", 32'(ifc.in_ready), 32'd1);
        got.delete();
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            if (ifc.out_valid && ifc.out_ready) got.push_back(ifc.result);
            tick();
            ifc.in_valid = 1'b0;
        end
        check("order_count", 32'(got.size()), 32'd5);
        for (int i = 0; i < got.size(); i++) begin
            check($sformatf("order_%0d", i), 32'(got[i]), 32'(i + 1));
        end

        // Reset with operations in flight
        ifc.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            ifc.a        = 16'(16'h0100 + i);
            ifc.in_valid = 1'b1;
            tick();
        end
        ifc.in_valid = 1'b0;
        tick();
        tick();
        check("inflight_valid", 32'(ifc.out_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        check("arst_out_valid", 32'(ifc.out_valid), 32'd0);
        check("arst_in_ready",  32'(ifc.in_ready),  32'd1);
        check("arst_result",    32'(ifc.result),    32'd0);
        tick();
        rst_n = 1'b1;
        ifc.out_ready = 1'b1;
        ifc.a         = 16'h0010;
        ifc.b         = 16'h0020;
        ifc.in_valid  = 1'b1;
        tick();
        ifc.in_valid = 1'b0;
        got.delete();
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (ifc.out_valid && ifc.out_ready) got.push_back(ifc.result);
        end
        check("post_rst_count", 32'(got.size()), 32'd1);
        if (got.size() > 0) check("post_rst_result", 32'(got[0]), 32'h0030);

        // Random traffic on all depths
        rnd_go = 1'b1;
        for (int c = 0; c < 30000 && rnd_done < 4; c++) @(posedge clk);
        check("random_done", 32'(rnd_done), 32'd4);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
